// File: rtl/reg_dump_pkg.sv
// ----------------------------------------------------------------------------
// reg_dump_pkg
// Shared definitions for the register-file dump engine.
//   - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default register address / data widths
//   - reg_dump_state_t                : dump FSM state encoding
// The CSUM state is part of the encoding in every build. It is only reachable
// when REG_DUMP_CHECKSUM_EN is defined.
// ----------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } reg_dump_state_t;

endpackage

// File: rtl/reg_dump_if.sv
// ----------------------------------------------------------------------------
// reg_dump_if
// Valid/ready stream carrying dumped register words to the debug/UART bridge.
//   out_valid  master -> slave  beat valid
//   out_ready  slave  -> master sink accepts the beat
//   out_data   master -> slave  register value or checksum
//   out_addr   master -> slave  register index of the beat (0 on checksum beat)
//   out_last   master -> slave  final beat of the dump
//   out_csum   master -> slave  beat carries the checksum
// Modports: master (the dump engine) and slave (the sink).
// ----------------------------------------------------------------------------
interface reg_dump_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  out_csum;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        output out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        input  out_csum,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// ----------------------------------------------------------------------------
// reg_dump
// Debug readout engine for the CPU register file. A dump_start pulse walks
// the register file read port from address 0 to REG_FILE_SIZE-1. Each word
// is captured into an output register and presented as one stream beat.
// Each word is captured just before its beat is presented, so a later write
// to a register that was already dumped does not change the dump.
//
// Parameters
//   ADDR_WIDTH     register address width
//   DATA_WIDTH     register data width
//   REG_FILE_SIZE  number of registers dumped (1 .. 2**ADDR_WIDTH)
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   dump_start  in   one-cycle dump request; ignored while a dump is running
//   reg_r_addr  out  register file read address
//   reg_r_data  in   combinational read data for reg_r_addr
//   busy        out  dump in progress
//   done        out  one-cycle pulse after the final beat is accepted
//   strm        reg_dump_if.master  output stream
//
// Build option
//   REG_DUMP_CHECKSUM_EN  when defined, an XOR of all dumped words is sent
//                         as one extra final beat with out_csum=1.
//
// State table
//   IDLE | waiting for dump_start
//   READ | read port addressed with idx; word captured at the clock edge
//   SEND | beat presented; held until out_ready
//   CSUM | checksum beat presented (checksum build only)
//   DONE | done pulse, dump finished
// ----------------------------------------------------------------------------
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int REG_FILE_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dump_start,
    output logic [ADDR_WIDTH-1:0] reg_r_addr,
    input  logic [DATA_WIDTH-1:0] reg_r_data,
    output logic                  busy,
    output logic                  done,
    reg_dump_if.master            strm
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_FILE_SIZE - 1);

    reg_dump_state_t       state;
    reg_dump_state_t       state_nxt;

    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_q;

    logic                  valid;
    logic                  hs;
    logic                  at_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc;
`endif

    assign at_last = (idx == LAST_IDX);
    assign hs      = valid && strm.out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = READ;
                end
            end

            READ: begin
                busy      = 1'b1;
                state_nxt = SEND;
            end

            SEND: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (hs) begin
                    if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = READ;
                    end
                end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                busy  = 1'b1;
                valid = 1'b1;
                if (hs) begin
                    state_nxt = DONE;
                end
            end
`endif

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index counter and beat capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            data_q <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        idx <= '0;
                    end
                end

                READ: begin
                    data_q <= reg_r_data;
                    addr_q <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
                    // The checksum beat is the last one, never a register beat.
                    last_q <= 1'b0;
`else
                    last_q <= at_last;
`endif
                end

                SEND: begin
                    if (hs) begin
                        // idx stops at LAST_IDX so it can never wrap.
                        if (!at_last) begin
                            idx <= idx + 1'b1;
                        end
`ifdef REG_DUMP_CHECKSUM_EN
                        else begin
                            // Load the checksum beat directly; the final word
                            // is folded in here since acc updates in parallel.
                            data_q <= acc ^ data_q;
                            addr_q <= '0;
                            last_q <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                end
            endcase
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // ------------------------------------------------------------------
    // XOR accumulator over accepted register beats
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (state == IDLE && dump_start) begin
            acc <= '0;
        end else if (state == SEND && hs) begin
            acc <= acc ^ data_q;
        end
    end

    assign strm.out_csum = (state == CSUM);
`else
    assign strm.out_csum = 1'b0;
`endif

    assign reg_r_addr    = idx;
    assign strm.out_valid = valid;
    assign strm.out_data  = data_q;
    assign strm.out_addr  = addr_q;
    assign strm.out_last  = last_q && valid;

endmodule

// File: tb/tb_reg_dump.sv
// ----------------------------------------------------------------------------
// tb_reg_dump
// Directed bench for reg_dump. dut0 dumps a 32-entry register file, dut1 a
// single-entry one. Builds with or without REG_DUMP_CHECKSUM_EN.
// ----------------------------------------------------------------------------
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    localparam int NREG = 32;

    logic        clk;
    logic        rst;
    logic        dump_start;
    logic        dump_start1;
    logic [4:0]  reg_r_addr;
    logic [4:0]  reg_r_addr1;
    logic [31:0] reg_r_data;
    logic [31:0] reg_r_data1;
    logic        busy, busy1;
    logic        done, done1;

    logic [31:0] rf [NREG];
    logic [31:0] rf1;

    reg_dump_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) sif ();
    reg_dump_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) sif1 ();

    reg_dump #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_FILE_SIZE(NREG)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .reg_r_addr (reg_r_addr),
        .reg_r_data (reg_r_data),
        .busy       (busy),
        .done       (done),
        .strm       (sif)
    );

    reg_dump #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_FILE_SIZE(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start1),
        .reg_r_addr (reg_r_addr1),
        .reg_r_data (reg_r_data1),
        .busy       (busy1),
        .done       (done1),
        .strm       (sif1)
    );

    assign reg_r_data  = rf[reg_r_addr];
    assign reg_r_data1 = (reg_r_addr1 == 5'd0) ? rf1 : 32'hBAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations collected by drive_dump
    int          b_addr [$];
    logic [31:0] b_data [$];
    bit          b_last [$];
    bit          b_csum [$];
    int          st_addr [$];
    logic [31:0] st_data [$];
    int          done_cnt;
    int          done_cyc;
    bit          done_busy;
    int          first_vcyc;
    bit          timed_out;
    bit          r_valid, r_busy, r_done;

    // Runs one dump on dut0 and records every accepted beat. Cycle numbers
    // count from the cycle in which dump_start is sampled (cycle 0).
    task automatic drive_dump(input int stall_addr, input int stall_len,
                              input int repulse_beat, input int wr_beat,
                              input int wr_addr, input logic [31:0] wr_val,
                              input int rst_beat);
        int cyc;
        int stall_left;
        bit stop;
        b_addr.delete(); b_data.delete(); b_last.delete(); b_csum.delete();
        st_addr.delete(); st_data.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        done_busy  = 1'b0;
        first_vcyc = -1;
        timed_out  = 1'b0;
        stall_left = stall_len;
        stop       = 1'b0;
        cyc        = 0;
        @(negedge clk);
        dump_start    = 1'b1;
        sif.out_ready = 1'b1;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            dump_start    = 1'b0;
            sif.out_ready = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc  = cyc;
                    done_busy = busy;
                end
            end
            if (sif.out_valid && first_vcyc < 0) first_vcyc = cyc;
            if (sif.out_valid) begin
                if (rst_beat == b_addr.size()) begin
                    rst           = 1'b1;
                    sif.out_ready = 1'b0;
                    @(negedge clk);
                    r_valid = sif.out_valid;
                    r_busy  = busy;
                    r_done  = done;
                    rst     = 1'b0;
                    sif.out_ready = 1'b1;
                    repeat (10) begin
                        @(negedge clk);
                        if (done) done_cnt++;
                    end
                    stop = 1'b1;
                end else if (stall_left > 0 && int'(sif.out_addr) == stall_addr) begin
                    sif.out_ready = 1'b0;
                    stall_left--;
                    st_addr.push_back(int'(sif.out_addr));
                    st_data.push_back(sif.out_data);
                end else begin
                    b_addr.push_back(int'(sif.out_addr));
                    b_data.push_back(sif.out_data);
                    b_last.push_back(sif.out_last);
                    b_csum.push_back(sif.out_csum);
                    if (b_addr.size() - 1 == repulse_beat) dump_start = 1'b1;
                    if (b_addr.size() - 1 == wr_beat) rf[wr_addr] = wr_val;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) stop = 1'b1;
            if (cyc >= 400) begin
                timed_out = 1'b1;
                stop      = 1'b1;
            end
        end
    endtask

    task automatic load_rf_base();
        for (int i = 0; i < NREG; i++) rf[i] = 32'h100 + i;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dump_start = 1'b0;
        dump_start1 = 1'b0;
        sif.out_ready = 1'b0;
        sif1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sif.out_valid, busy, done, sif.out_last, sif.out_csum} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/busy/done/last/csum=%b, need 00000",
                     {sif.out_valid, busy, done, sif.out_last, sif.out_csum});
        end
        checks++;
        if (sif.out_data !== 32'h0 || sif.out_addr !== 5'd0 || reg_r_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%h addr=%0d raddr=%0d, need 0/0/0",
                     sif.out_data, sif.out_addr, reg_r_addr);
        end
        checks++;
        if ({sif1.out_valid, busy1, done1} !== 3'b0) begin
            errors++;
            $display("FAIL reset_dut1: got valid/busy/done=%b, need 000",
                     {sif1.out_valid, busy1, done1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        int nexp;
        logic [31:0] acc;
        load_rf_base();
        drive_dump(-1, 0, -1, -1, 0, 32'h0, -1);
        nexp = NREG + CSUM_EN;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL full_timeout: got timeout, need done within 400 cycles");
        end
        checks++;
        if (b_addr.size() != nexp) begin
            errors++;
            $display("FAIL full_beats: got %0d beats, need %0d", b_addr.size(), nexp);
        end
        checks++;
        if (first_vcyc != 2) begin
            errors++;
            $display("FAIL full_first_valid: got cycle %0d, need 2", first_vcyc);
        end
        checks++;
        if (done_cyc != 2 * NREG + 1 + CSUM_EN || done_cnt != 1 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got cycle %0d count %0d busy %b, need %0d/1/0",
                     done_cyc, done_cnt, done_busy, 2 * NREG + 1 + CSUM_EN);
        end
        acc = 32'h0;
        for (int i = 0; i < NREG && i < b_addr.size(); i++) begin
            acc ^= 32'h100 + i;
            checks++;
            if (b_addr[i] != i || b_data[i] !== 32'h100 + i ||
                b_last[i] !== ((i == NREG - 1) && (CSUM_EN == 0)) || b_csum[i] !== 1'b0) begin
                errors++;
                $display("FAIL full_beat%0d: got addr %0d data %h last %b csum %b, need %0d/%h/%b/0",
                         i, b_addr[i], b_data[i], b_last[i], b_csum[i], i, 32'h100 + i,
                         (i == NREG - 1) && (CSUM_EN == 0));
            end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        checks++;
        if (b_addr.size() != NREG + 1 || b_data[NREG] !== acc || b_csum[NREG] !== 1'b1 ||
            b_last[NREG] !== 1'b1 || b_addr[NREG] != 0) begin
            errors++;
            $display("FAIL full_csum_beat: got %0d beats, need final beat data %h csum 1 last 1 addr 0",
                     b_addr.size(), acc);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit seq_ok;
        load_rf_base();
        drive_dump(3, 5, -1, -1, 0, 32'h0, -1);
        checks++;
        if (st_addr.size() != 5) begin
            errors++;
            $display("FAIL bp_stall_len: got %0d stalled cycles, need 5", st_addr.size());
        end
        for (int i = 0; i < st_addr.size(); i++) begin
            checks++;
            if (st_addr[i] != 3 || st_data[i] !== 32'h103) begin
                errors++;
                $display("FAIL bp_hold%0d: got addr %0d data %h, need 3/00000103",
                         i, st_addr[i], st_data[i]);
            end
        end
        seq_ok = (b_addr.size() == NREG + CSUM_EN);
        for (int i = 0; i < NREG && i < b_addr.size(); i++)
            if (b_addr[i] != i || b_data[i] !== 32'h100 + i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL bp_sequence: got %0d beats or out-of-order data, need %0d in order",
                     b_addr.size(), NREG + CSUM_EN);
        end
        checks++;
        if (done_cyc != 2 * NREG + 1 + CSUM_EN + 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done: got cycle %0d count %0d, need %0d/1",
                     done_cyc, done_cnt, 2 * NREG + 1 + CSUM_EN + 5);
        end
    endtask

    task automatic test_restart_ignored();
        bit seq_ok;
        load_rf_base();
        drive_dump(-1, 0, 10, -1, 0, 32'h0, -1);
        seq_ok = (b_addr.size() == NREG + CSUM_EN);
        for (int i = 0; i < NREG && i < b_addr.size(); i++)
            if (b_addr[i] != i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL restart_beats: got %0d beats, need %0d in order",
                     b_addr.size(), NREG + CSUM_EN);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 2 * NREG + 1 + CSUM_EN) begin
            errors++;
            $display("FAIL restart_done: got count %0d cycle %0d, need 1/%0d",
                     done_cnt, done_cyc, 2 * NREG + 1 + CSUM_EN);
        end
    endtask

    task automatic test_reset_mid();
        load_rf_base();
        r_valid = 1'b1; r_busy = 1'b1; r_done = 1'b1;
        drive_dump(-1, 0, -1, -1, 0, 32'h0, 7);
        checks++;
        if (b_addr.size() != 7) begin
            errors++;
            $display("FAIL rstmid_beats: got %0d beats before reset, need 7", b_addr.size());
        end
        checks++;
        if ({r_valid, r_busy, r_done} !== 3'b000 || done_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_state: got valid/busy/done=%b done_count %0d, need 000/0",
                     {r_valid, r_busy, r_done}, done_cnt);
        end
        drive_dump(-1, 0, -1, -1, 0, 32'h0, -1);
        checks++;
        if (b_addr.size() != NREG + CSUM_EN || b_addr[0] != 0 || b_data[0] !== 32'h100 ||
            done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_fresh: got %0d beats, first addr %0d data %h, done %0d; need %0d/0/100/1",
                     b_addr.size(), b_addr.size() > 0 ? b_addr[0] : -1,
                     b_data.size() > 0 ? b_data[0] : 32'hx, done_cnt, NREG + CSUM_EN);
        end
    endtask

    task automatic test_snapshot();
        load_rf_base();
        drive_dump(-1, 0, -1, 5, 20, 32'hDEAD, -1);
        checks++;
        if (b_data.size() <= 20 || b_data[20] !== 32'hDEAD) begin
            errors++;
            $display("FAIL snap_beat20: got %h, need 0000dead",
                     b_data.size() > 20 ? b_data[20] : 32'hx);
        end
        checks++;
        if (b_data.size() <= 5 || b_data[5] !== 32'h105) begin
            errors++;
            $display("FAIL snap_beat5: got %h, need 00000105",
                     b_data.size() > 5 ? b_data[5] : 32'hx);
        end
        load_rf_base();
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < NREG; i++) rf[i] = i;
        drive_dump(-1, 0, -1, -1, 0, 32'h0, -1);
        checks++;
        if (b_addr.size() != NREG + 1) begin
            errors++;
            $display("FAIL csum_beats: got %0d beats, need %0d", b_addr.size(), NREG + 1);
        end else begin
            checks++;
            if (b_data[NREG] !== 32'h0 || b_csum[NREG] !== 1'b1 || b_last[NREG] !== 1'b1) begin
                errors++;
                $display("FAIL csum_final: got data %h csum %b last %b, need 0/1/1",
                         b_data[NREG], b_csum[NREG], b_last[NREG]);
            end
            checks++;
            if (b_last[NREG-1] !== 1'b0 || b_data[NREG-1] !== 32'd31) begin
                errors++;
                $display("FAIL csum_prev: got last %b data %h, need 0/0000001f",
                         b_last[NREG-1], b_data[NREG-1]);
            end
        end
        load_rf_base();
    endtask
`endif

    task automatic test_size_one();
        int          n;
        int          dcyc;
        int          cyc;
        int          a1 [$];
        logic [31:0] d1 [$];
        bit          l1 [$];
        bit          c1 [$];
        rf1  = 32'd7;
        dcyc = -1;
        n    = 0;
        sif1.out_ready = 1'b1;
        @(negedge clk);
        dump_start1 = 1'b1;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            dump_start1 = 1'b0;
            if (done1) begin
                n++;
                if (dcyc < 0) dcyc = cyc;
            end
            if (sif1.out_valid) begin
                a1.push_back(int'(sif1.out_addr));
                d1.push_back(sif1.out_data);
                l1.push_back(sif1.out_last);
                c1.push_back(sif1.out_csum);
            end
        end
        checks++;
        if (a1.size() != 1 + CSUM_EN) begin
            errors++;
            $display("FAIL one_beats: got %0d beats, need %0d", a1.size(), 1 + CSUM_EN);
        end else begin
            checks++;
            if (a1[0] != 0 || d1[0] !== 32'd7 || l1[0] !== (CSUM_EN == 0) || c1[0] !== 1'b0) begin
                errors++;
                $display("FAIL one_beat0: got addr %0d data %h last %b csum %b, need 0/7/%b/0",
                         a1[0], d1[0], l1[0], c1[0], CSUM_EN == 0);
            end
`ifdef REG_DUMP_CHECKSUM_EN
            checks++;
            if (a1[1] != 0 || d1[1] !== 32'd7 || l1[1] !== 1'b1 || c1[1] !== 1'b1) begin
                errors++;
                $display("FAIL one_csum: got addr %0d data %h last %b csum %b, need 0/7/1/1",
                         a1[1], d1[1], l1[1], c1[1]);
            end
`endif
        end
        checks++;
        if (n != 1 || dcyc != 3 + CSUM_EN) begin
            errors++;
            $display("FAIL one_done: got count %0d cycle %0d, need 1/%0d", n, dcyc, 3 + CSUM_EN);
        end
    endtask

    initial begin
        rst            = 1'b1;
        dump_start     = 1'b0;
        dump_start1    = 1'b0;
        sif.out_ready  = 1'b0;
        sif1.out_ready = 1'b0;
        rf1            = 32'd0;
        load_rf_base();
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_snapshot();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        test_size_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
